// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor pipeline.
//   - Datapath and register-index widths.
//   - Opcode constants for the non-ALU and halt instructions.
//   - Halt-drain FSM state encoding and the latched control bundle.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_SLBI = 5'b10010;
    localparam logic [4:0] OP_LBI  = 5'b11000;
    localparam logic [4:0] OP_BTR  = 5'b11001;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

    // Decoded controls that travel with an instruction into the memory stage.
    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic halt;
    } mem_ctrl_t;

endpackage

// File: rtl/pipe_dff_en.sv
// Width-parameterised pipeline flop.
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   en         : update enable; when low the flop holds regardless of clr
//   clr        : synchronous clear, effective only while en is high
//   d / q      : data in / registered data out
module pipe_dff_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d;

    // Enable gates the clear too, so a hold always wins over a squash.
    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = clr ? '0 : d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with stall, flush, halt drain and forwarding.
//   Inputs  : ex_* fields from execute, stall (hold everything), flush
//             (squash incoming instruction).
//   Outputs : mem_* latched fields, fwd_valid/fwd_reg back to execute,
//             halted once HALT has drained out of this stage.
//   Optional: define EX_MEM_PERF_EN to add stall_cnt / bubble_cnt
//             saturating 16-bit performance counters.
module ex_mem_stage #(
    parameter int DATA_W     = cpu_pkg::DATA_W,
    parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic [15:0]           ex_instr,
    input  logic [DATA_W-1:0]     ex_alu_res,
    input  logic [DATA_W-1:0]     ex_non_alu_res,
    input  logic                  ex_alu_res_ctrl,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_wr_reg,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_halt,
    input  logic                  stall,
    input  logic                  flush,
    output logic                  mem_valid,
    output logic [15:0]           mem_instr,
    output logic [DATA_W-1:0]     mem_result,
    output logic [DATA_W-1:0]     mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_wr_reg,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_halt,
    output logic                  fwd_valid,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic                  halted
`ifdef EX_MEM_PERF_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           bubble_cnt
`endif
);

    import cpu_pkg::*;

    halt_state_t state_q, state_d;

    logic              load_en;
    logic              bubble;
    logic [DATA_W-1:0] sel_res;
    mem_ctrl_t         ex_ctrl;
    mem_ctrl_t         mem_ctrl;

    assign load_en = ~stall;
    // Once HALT is accepted nothing else may enter, so any non-RUN state squashes.
    assign bubble  = flush | (state_q != RUN) | ~ex_valid;
    assign sel_res = ex_alu_res_ctrl ? ex_non_alu_res : ex_alu_res;

    assign ex_ctrl.reg_write = ex_reg_write;
    assign ex_ctrl.mem_read  = ex_mem_read;
    assign ex_ctrl.mem_write = ex_mem_write;
    assign ex_ctrl.halt      = ex_halt;

    // ---------------- Pipeline fields ----------------
    pipe_dff_en #(.W(1)) u_valid (
        .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble),
        .d(1'b1), .q(mem_valid)
    );

    pipe_dff_en #(.W(16)) u_instr (
        .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble),
        .d(ex_instr), .q(mem_instr)
    );

    pipe_dff_en #(.W(DATA_W)) u_result (
        .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble),
        .d(sel_res), .q(mem_result)
    );

    pipe_dff_en #(.W(DATA_W)) u_store (
        .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble),
        .d(ex_store_data), .q(mem_store_data)
    );

    pipe_dff_en #(.W(REG_ADDR_W)) u_wr_reg (
        .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble),
        .d(ex_wr_reg), .q(mem_wr_reg)
    );

    pipe_dff_en #(.W($bits(mem_ctrl_t))) u_ctrl (
        .clk(clk), .rst_n(rst_n), .en(load_en), .clr(bubble),
        .d(ex_ctrl), .q(mem_ctrl)
    );

    assign mem_reg_write = mem_ctrl.reg_write;
    assign mem_mem_read  = mem_ctrl.mem_read;
    assign mem_mem_write = mem_ctrl.mem_write;
    assign mem_halt      = mem_ctrl.halt;

    // ---------------- Halt-drain FSM ----------------
    always_comb begin
        state_d = state_q;
        if (!stall) begin
            unique case (state_q)
                RUN:     if (!bubble && ex_halt) state_d = DRAIN;
                DRAIN:   state_d = HALTED;  // HALT leaves, bubble enters
                HALTED:  state_d = HALTED;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign halted = (state_q == HALTED);

    // ---------------- Forwarding ----------------
    // Load data only exists after the memory access, so loads never forward here.
    assign fwd_valid = mem_valid & mem_reg_write & ~mem_mem_read;
    assign fwd_reg   = mem_wr_reg;

`ifdef EX_MEM_PERF_EN
    // ---------------- Performance counters ----------------
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic        cnt_frozen;

    assign cnt_frozen = (state_q == HALTED);

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!cnt_frozen) begin
            if (stall && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
            if (!stall && bubble && bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_d = bubble_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed scenarios then randomized
// traffic compared against a behavioural model of the stage.
module tb_ex_mem_stage;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ex_valid = 1'b0;
    logic [15:0]   ex_instr = '0;
    logic [DW-1:0] ex_alu_res = '0;
    logic [DW-1:0] ex_non_alu_res = '0;
    logic          ex_alu_res_ctrl = 1'b0;
    logic [DW-1:0] ex_store_data = '0;
    logic [AW-1:0] ex_wr_reg = '0;
    logic          ex_reg_write = 1'b0;
    logic          ex_mem_read = 1'b0;
    logic          ex_mem_write = 1'b0;
    logic          ex_halt = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;

    logic          mem_valid;
    logic [15:0]   mem_instr;
    logic [DW-1:0] mem_result;
    logic [DW-1:0] mem_store_data;
    logic [AW-1:0] mem_wr_reg;
    logic          mem_reg_write, mem_mem_read, mem_mem_write, mem_halt;
    logic          fwd_valid;
    logic [AW-1:0] fwd_reg;
    logic          halted;
`ifdef EX_MEM_PERF_EN
    logic [15:0]   stall_cnt, bubble_cnt;
`endif

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_instr(ex_instr),
        .ex_alu_res(ex_alu_res), .ex_non_alu_res(ex_non_alu_res),
        .ex_alu_res_ctrl(ex_alu_res_ctrl), .ex_store_data(ex_store_data),
        .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_halt(ex_halt), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_wr_reg(mem_wr_reg), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_halt(mem_halt), .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
        .halted(halted)
`ifdef EX_MEM_PERF_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the memory stage currently holds.
    logic          m_valid, m_rw, m_mr, m_mw, m_halt;
    logic [15:0]   m_instr;
    logic [DW-1:0] m_res, m_st;
    logic [AW-1:0] m_wr;
    bit            m_draining, m_halted;
    int            m_scnt, m_bcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_halt = 0;
        m_instr = '0; m_res = '0; m_st = '0; m_wr = '0;
        m_draining = 0; m_halted = 0; m_scnt = 0; m_bcnt = 0;
    endtask

    // One clock edge as the stage's rules describe it.
    task automatic model_edge();
        if (stall) begin
            if (!m_halted && m_scnt < 65535) m_scnt++;
        end else if (flush || m_draining || m_halted || !ex_valid) begin
            if (!m_halted && m_bcnt < 65535) m_bcnt++;
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_halt = 0;
            m_instr = '0; m_res = '0; m_st = '0; m_wr = '0;
            if (m_draining) begin
                m_draining = 0;
                m_halted   = 1;
            end
        end else begin
            m_valid = 1;
            m_instr = ex_instr;
            m_res   = ex_alu_res_ctrl ? ex_non_alu_res : ex_alu_res;
            m_st    = ex_store_data;
            m_wr    = ex_wr_reg;
            m_rw    = ex_reg_write;
            m_mr    = ex_mem_read;
            m_mw    = ex_mem_write;
            m_halt  = ex_halt;
            if (ex_halt) m_draining = 1;
        end
    endtask

    task automatic check_all();
        chk("mem_valid",      {31'd0, mem_valid},      {31'd0, m_valid});
        chk("mem_instr",      {16'd0, mem_instr},      {16'd0, m_instr});
        chk("mem_result",     {16'd0, mem_result},     {16'd0, m_res});
        chk("mem_store_data", {16'd0, mem_store_data}, {16'd0, m_st});
        chk("mem_wr_reg",     {29'd0, mem_wr_reg},     {29'd0, m_wr});
        chk("mem_ctrl",       {28'd0, mem_reg_write, mem_mem_read, mem_mem_write, mem_halt},
                              {28'd0, m_rw, m_mr, m_mw, m_halt});
        chk("fwd_valid",      {31'd0, fwd_valid},      {31'd0, m_valid & m_rw & ~m_mr});
        chk("fwd_reg",        {29'd0, fwd_reg},        {29'd0, m_wr});
        chk("halted",         {31'd0, halted},         {31'd0, m_halted});
`ifdef EX_MEM_PERF_EN
        chk("stall_cnt",      {16'd0, stall_cnt},      m_scnt);
        chk("bubble_cnt",     {16'd0, bubble_cnt},     m_bcnt);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse taken between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_in();
        ex_valid = 0; ex_instr = '0; ex_alu_res = '0; ex_non_alu_res = '0;
        ex_alu_res_ctrl = 0; ex_store_data = '0; ex_wr_reg = '0;
        ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_halt = 0;
        stall = 0; flush = 0;
    endtask

    task automatic rand_in();
        ex_valid        = ($urandom_range(0, 9) < 8);
        ex_instr        = 16'($urandom);
        ex_alu_res      = 16'($urandom);
        ex_non_alu_res  = 16'($urandom);
        ex_alu_res_ctrl = 1'($urandom);
        ex_store_data   = 16'($urandom);
        ex_wr_reg       = 3'($urandom);
        ex_reg_write    = 1'($urandom);
        ex_mem_read     = ($urandom_range(0, 3) == 0);
        ex_mem_write    = ($urandom_range(0, 3) == 0);
        ex_halt         = ($urandom_range(0, 49) == 0);
        stall           = ($urandom_range(0, 3) == 0);
        flush           = ($urandom_range(0, 9) == 0);
    endtask

    initial begin
        model_reset();
        clear_in();
        #12;
        check_all();                        // held in reset
        @(negedge clk);
        rst_n = 1'b1;

        // ALU result capture and forwarding
        ex_valid = 1; ex_alu_res = 16'h1234; ex_reg_write = 1; ex_wr_reg = 3'd3;
        step();
        chk("alu_sel", {16'd0, mem_result}, 32'h1234);
        chk("fwd_on",  {31'd0, fwd_valid},  32'd1);
        chk("fwd_r3",  {29'd0, fwd_reg},    32'd3);

        // Non-ALU (LBI) result select
        ex_alu_res_ctrl = 1; ex_non_alu_res = 16'hFF80; ex_alu_res = 16'h5555;
        step();
        chk("lbi_sel", {16'd0, mem_result}, 32'hFF80);

        // Stall holds contents while inputs change
        ex_alu_res_ctrl = 0; ex_alu_res = 16'hABCD;
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            ex_alu_res = 16'($urandom); ex_instr = 16'($urandom);
            step();
        end
        chk("stall_hold", {16'd0, mem_result}, 32'hABCD);
`ifdef EX_MEM_PERF_EN
        chk("stall_cnt3", {16'd0, stall_cnt}, 32'd3);
`endif

        // Stall beats flush; then flush alone loads an all-zero bubble
        flush = 1;
        step();
        chk("stall_over_flush", {16'd0, mem_result}, 32'hABCD);
        stall = 0;
        step();
        chk("flush_valid", {31'd0, mem_valid},  32'd0);
        chk("flush_res",   {16'd0, mem_result}, 32'd0);
        chk("flush_instr", {16'd0, mem_instr},  32'd0);
        flush = 0;

        // Loads never forward
        ex_mem_read = 1; ex_reg_write = 1; ex_alu_res = 16'h0042;
        step();
        chk("load_mr",  {31'd0, mem_mem_read}, 32'd1);
        chk("load_fwd", {31'd0, fwd_valid},    32'd0);
        ex_mem_read = 0;

        // HALT drain
        ex_halt = 1;
        step();
        chk("halt_in",   {31'd0, mem_halt}, 32'd1);
        chk("halt_not_yet", {31'd0, halted}, 32'd0);
        ex_halt = 0;
        step();
        chk("halt_drained", {31'd0, mem_valid}, 32'd0);
        chk("halted_set",   {31'd0, halted},    32'd1);
        for (int i = 0; i < 4; i++) step();
        chk("halted_blocks", {31'd0, mem_valid}, 32'd0);
        do_reset();
        chk("halted_cleared", {31'd0, halted}, 32'd0);

        // Randomized traffic, with occasional async resets mid-stream
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 300; c++) begin
                rand_in();
                step();
                if ($urandom_range(0, 99) == 0) do_reset();
            end
            clear_in();
            do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
